// File: rtl/fifo_write_arbiter_if.sv
// Write-side bus between NUM_REQ requesters, the burst arbiter and the async FIFO write logic.
// The arbiter takes the slave modport; requesters and FIFO status take the master modport.
interface fifo_write_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_Valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_Data;
    logic [NUM_REQ-1:0]            req_Last;
    logic [NUM_REQ-1:0]            req_Ready;
    logic                          fifo_Full;
    logic                          w_Inc;
    logic [DATA_WIDTH-1:0]         w_Data;
    logic [ID_W-1:0]               grant_Id;
    logic                          busy;

    modport slave (
        input  req_Valid, req_Data, req_Last, fifo_Full,
        output req_Ready, w_Inc, w_Data, grant_Id, busy
    );

    modport master (
        output req_Valid, req_Data, req_Last, fifo_Full,
        input  req_Ready, w_Inc, w_Data, grant_Id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Burst-locked arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Define WARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                w_Clk,
    input  logic                w_Rst,
    fifo_write_arbiter_if.slave arb
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic             xfer;
    logic             burst_done;

`ifndef WARB_FIXED_PRIO_EN
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_nxt;
    logic [ID_W:0]    cand;
    logic             found;
`endif

    assign any_valid = |arb.req_Valid;

`ifdef WARB_FIXED_PRIO_EN
    // Lowest valid index wins; scanning downward leaves the smallest index last.
    always_comb begin
        winner = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (arb.req_Valid[k]) begin
                winner = ID_W'(k);
            end
        end
    end
`else
    // Round-robin search from rr_ptr, wrapping NUM_REQ-1 -> 0 (NUM_REQ need not be a power of two).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && arb.req_Valid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    assign grant_nxt = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif

    // Next-state and same-cycle handshake outputs; fifo_Full masks everything.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
`ifndef WARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        xfer          = 1'b0;
        burst_done    = 1'b0;
        arb.req_Ready = '0;
        arb.w_Inc     = 1'b0;
        arb.w_Data    = arb.req_Data[grant_q*DATA_WIDTH +: DATA_WIDTH];

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d    = BURST;
                    grant_d    = winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                xfer                   = arb.req_Valid[grant_q] & ~arb.fifo_Full;
                arb.req_Ready[grant_q] = ~arb.fifo_Full;
                arb.w_Inc              = xfer;
                burst_done = arb.req_Last[grant_q] ||
                             (beat_cnt_q == CNT_W'(MAX_BURST - 1));
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (burst_done) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
`ifndef WARB_FIXED_PRIO_EN
                        rr_ptr_d   = grant_nxt;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_Clk or negedge w_Rst) begin
        if (!w_Rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
`ifndef WARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
`ifndef WARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign arb.grant_Id = grant_q;
    assign arb.busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_fifo_write_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic w_Clk = 1'b0;
    logic w_Rst = 1'b0;
    always #5 w_Clk = ~w_Clk;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .w_Clk (w_Clk),
        .w_Rst (w_Rst),
        .arb   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        full;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic [3:0]  e_rdy;
        logic        e_inc;
        logic [7:0]  e_wd;
        logic [1:0]  e_gnt;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic full, input logic [3:0] valid,
                               input logic [3:0] last, input logic [31:0] data,
                               input logic [3:0] e_rdy, input logic e_inc, input logic [7:0] e_wd,
                               input logic [1:0] e_gnt, input logic e_busy);
        vec_t r;
        r.rst = rst; r.full = full; r.valid = valid; r.last = last; r.data = data;
        r.e_rdy = e_rdy; r.e_inc = e_inc; r.e_wd = e_wd; r.e_gnt = e_gnt; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic full, input logic [3:0] valid,
                         input logic [3:0] last, input logic [31:0] data);
        w_Rst         = rst;
        bus.fifo_Full = full;
        bus.req_Valid = valid;
        bus.req_Last  = last;
        bus.req_Data  = data;
    endtask

    task automatic cyc(input logic rst, input logic full, input logic [3:0] valid,
                       input logic [3:0] last, input logic [31:0] data);
        @(posedge w_Clk);
        #1;
        drive(rst, full, valid, last, data);
        @(negedge w_Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p3;
        logic [7:0] b;
        logic [1:0] exp_g [4];
        int idx;
        int gcount;

        drive(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0);

        // Reset release with FIFO full, requester 0 waiting.
        tbl.push_back(v(0,1,4'b0001,4'b0000,32'h00000001, 4'b0000,0,8'h00,2'd0,0));
        tbl.push_back(v(1,1,4'b0001,4'b0000,32'h00000001, 4'b0000,0,8'h00,2'd0,0));
        tbl.push_back(v(1,1,4'b0001,4'b0000,32'h00000001, 4'b0000,0,8'h00,2'd0,1));
        tbl.push_back(v(1,1,4'b0001,4'b0000,32'h00000001, 4'b0000,0,8'h00,2'd0,1));
        tbl.push_back(v(1,0,4'b0001,4'b0000,32'h00000001, 4'b0001,1,8'h01,2'd0,1));
        tbl.push_back(v(1,0,4'b0001,4'b0000,32'h00000002, 4'b0001,1,8'h02,2'd0,1));
        tbl.push_back(v(1,0,4'b0001,4'b0001,32'h00000003, 4'b0001,1,8'h03,2'd0,1));
        tbl.push_back(v(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,2'd0,0));
        // All four requesters, two beats each, from a fresh reset.
        tbl.push_back(v(0,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,2'd0,0));
        tbl.push_back(v(1,0,4'b1111,4'b0000,32'h31211101, 4'b0000,0,8'h00,2'd0,0));
        tbl.push_back(v(1,0,4'b1111,4'b0000,32'h31211101, 4'b0001,1,8'h01,2'd0,1));
        tbl.push_back(v(1,0,4'b1111,4'b0001,32'h31211102, 4'b0001,1,8'h02,2'd0,1));
        tbl.push_back(v(1,0,4'b1110,4'b0000,32'h31211100, 4'b0000,0,8'h00,2'd0,0));
        tbl.push_back(v(1,0,4'b1110,4'b0000,32'h31211100, 4'b0010,1,8'h11,2'd1,1));
        tbl.push_back(v(1,0,4'b1110,4'b0010,32'h31211200, 4'b0010,1,8'h12,2'd1,1));
        tbl.push_back(v(1,0,4'b1100,4'b0000,32'h31211200, 4'b0000,0,8'h00,2'd1,0));
        tbl.push_back(v(1,0,4'b1100,4'b0000,32'h31210000, 4'b0100,1,8'h21,2'd2,1));
        tbl.push_back(v(1,0,4'b1100,4'b0100,32'h31220000, 4'b0100,1,8'h22,2'd2,1));
        tbl.push_back(v(1,0,4'b1000,4'b0000,32'h31000000, 4'b0000,0,8'h00,2'd2,0));
        tbl.push_back(v(1,0,4'b1000,4'b0000,32'h31000000, 4'b1000,1,8'h31,2'd3,1));
        tbl.push_back(v(1,0,4'b1000,4'b1000,32'h32000000, 4'b1000,1,8'h32,2'd3,1));
        tbl.push_back(v(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,2'd3,0));
        // Move rr_ptr to 2, then reset in the middle of a burst from requester 2.
        tbl.push_back(v(1,0,4'b0010,4'b0010,32'h00001500, 4'b0000,0,8'h00,2'd3,0));
        tbl.push_back(v(1,0,4'b0010,4'b0010,32'h00001500, 4'b0010,1,8'h15,2'd1,1));
        tbl.push_back(v(1,0,4'b0100,4'b0000,32'h00410000, 4'b0000,0,8'h00,2'd1,0));
        tbl.push_back(v(1,0,4'b0100,4'b0000,32'h00410000, 4'b0100,1,8'h41,2'd2,1));
        tbl.push_back(v(1,0,4'b0100,4'b0000,32'h00420000, 4'b0100,1,8'h42,2'd2,1));
        tbl.push_back(v(0,0,4'b0100,4'b0000,32'h00430000, 4'b0000,0,8'h00,2'd0,0));
        tbl.push_back(v(1,0,4'b0110,4'b0010,32'h00435100, 4'b0000,0,8'h00,2'd0,0));
        tbl.push_back(v(1,0,4'b0110,4'b0010,32'h00435100, 4'b0010,1,8'h51,2'd1,1));
        tbl.push_back(v(1,0,4'b0000,4'b0000,32'h00000000, 4'b0000,0,8'h00,2'd1,0));

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].full, tbl[i].valid, tbl[i].last, tbl[i].data);
            chk($sformatf("v%0d.ready", i), 32'(bus.req_Ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.w_inc", i), 32'(bus.w_Inc),     32'(tbl[i].e_inc));
            chk($sformatf("v%0d.grant", i), 32'(bus.grant_Id),  32'(tbl[i].e_gnt));
            chk($sformatf("v%0d.busy", i),  32'(bus.busy),      32'(tbl[i].e_busy));
            if (tbl[i].e_inc) begin
                chk($sformatf("v%0d.w_data", i), 32'(bus.w_Data), 32'(tbl[i].e_wd));
            end
        end

        // Requester 2, six beats without last: MAX_BURST splits it 4 + 2 with one idle cycle.
        p3  = 8'b1101_1110;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            b = 8'(8'h61 + idx);
            cyc(1'b1, 1'b0, (idx < 6) ? 4'b0100 : 4'b0000, 4'b0000, {8'h00, b, 16'h0000});
            chk($sformatf("maxb.c%0d.w_inc", c), 32'(bus.w_Inc), 32'(p3[c]));
            chk($sformatf("maxb.c%0d.busy", c),  32'(bus.busy),  32'(p3[c]));
            if (bus.w_Inc) begin
                chk($sformatf("maxb.c%0d.w_data", c), 32'(bus.w_Data), 32'(b));
                chk($sformatf("maxb.c%0d.grant", c),  32'(bus.grant_Id), 32'd2);
                idx++;
            end
        end
        chk("maxb.beats", 32'(idx), 32'd6);

        // Full toggling every other cycle; last beat coincides with the MAX_BURST limit.
        cyc(1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0);
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            b = 8'(8'h71 + idx);
            cyc(1'b1, 1'(c % 2), 4'b0001, (idx == 3) ? 4'b0001 : 4'b0000, {24'h0, b});
            if (bus.fifo_Full) begin
                chk($sformatf("full.c%0d.w_inc", c), 32'(bus.w_Inc), 32'd0);
                chk($sformatf("full.c%0d.ready", c), 32'(bus.req_Ready), 32'd0);
            end
            if (bus.w_Inc) begin
                chk($sformatf("full.c%0d.w_data", c), 32'(bus.w_Data), 32'(b));
                idx++;
            end
        end
        chk("full.beats", 32'(idx), 32'd4);
        for (int c = 0; c < 2; c++) begin
            cyc(1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0);
            chk($sformatf("full.after%0d.busy", c),  32'(bus.busy),  32'd0);
            chk($sformatf("full.after%0d.w_inc", c), 32'(bus.w_Inc), 32'd0);
        end

        // Requesters 1 and 3 held valid with single-beat bursts; rr_ptr starts at 1.
`ifdef WARB_FIXED_PRIO_EN
        exp_g[0] = 2'd1; exp_g[1] = 2'd1; exp_g[2] = 2'd1; exp_g[3] = 2'd1;
`else
        exp_g[0] = 2'd1; exp_g[1] = 2'd3; exp_g[2] = 2'd1; exp_g[3] = 2'd3;
`endif
        gcount = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b0, 4'b1010, 4'b1010, 32'hB300B100);
            if (bus.w_Inc && gcount < 4) begin
                chk($sformatf("prio.g%0d.grant", gcount), 32'(bus.grant_Id), 32'(exp_g[gcount]));
                chk($sformatf("prio.g%0d.w_data", gcount), 32'(bus.w_Data),
                    (exp_g[gcount] == 2'd1) ? 32'hB1 : 32'hB3);
                gcount++;
            end
        end
        chk("prio.grants", 32'(gcount), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
